// File: rtl/dcache_pkg.sv
// Shared types and lane helpers for the data cache miss controller.
// Imported by dcache_miss_ctrl and dcache_perf_cnt.
package dcache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      FILL,
      WR_REQ
   } state_t;

   typedef enum logic [2:0] {
      WD_W  = 3'b000,
      WD_H  = 3'b001,
      WD_B  = 3'b010,
      WD_HU = 3'b101,
      WD_BU = 3'b110
   } width_t;

   localparam logic [3:0] BE_ALL = 4'b1111;

   function automatic logic [3:0] be_from_width(
      input logic [2:0] width,
      input logic [1:0] off
   );
      logic [3:0] be;
      be = BE_ALL;
      case (width)
         WD_H, WD_HU: be = off[1] ? 4'b1100 : 4'b0011;
         WD_B, WD_BU: be = 4'b0001 << off;
         default:     be = BE_ALL;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_data(
      input logic [2:0]  width,
      input logic [31:0] wdata
   );
      logic [31:0] d;
      d = wdata;
      case (width)
         WD_H, WD_HU: d = {2{wdata[15:0]}};
         WD_B, WD_BU: d = {4{wdata[7:0]}};
         default:     d = wdata;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extract(
      input logic [31:0] word,
      input logic [2:0]  width,
      input logic [1:0]  off
   );
      logic [15:0] h;
      logic [7:0]  b;
      logic [31:0] d;
      h = off[1] ? word[31:16] : word[15:0];
      b = word[{off, 3'b000} +: 8];
      case (width)
         WD_H:    d = {{16{h[15]}}, h};
         WD_HU:   d = {16'h0000, h};
         WD_B:    d = {{24{b[7]}}, b};
         WD_BU:   d = {24'h000000, b};
         default: d = word;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dcache_perf_cnt.sv
// Wrapping event counters for cache hits, misses and stores.
// Only instantiated when DCACHE_PERF_EN is defined.
module dcache_perf_cnt
   import dcache_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hit_inc,
   input  logic        miss_inc,
   input  logic        wr_inc,
   output logic [31:0] perf_hits,
   output logic [31:0] perf_misses,
   output logic [31:0] perf_wr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_hits   <= '0;
         perf_misses <= '0;
         perf_wr     <= '0;
      end else begin
         if (hit_inc)  perf_hits   <= perf_hits + 32'd1;
         if (miss_inc) perf_misses <= perf_misses + 32'd1;
         if (wr_inc)   perf_wr     <= perf_wr + 32'd1;
      end
   end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data cache sequencer: hit loads, read-miss refill, write-through stores.
// Define DCACHE_PERF_EN to add perf_hits/perf_misses/perf_wr counters.
module dcache_miss_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TO_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [2:0]        cpu_width,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   input  logic              c_hit,
   input  logic [DATA_W-1:0] c_rdata,
   output logic              c_fill,
   output logic              c_wr,
   output logic [3:0]        c_be,
   output logic [DATA_W-1:0] c_wdata,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [3:0]        ram_be,
   input  logic              ram_ack,
   input  logic              ram_rvalid,
   input  logic [DATA_W-1:0] ram_rdata
`ifdef DCACHE_PERF_EN
  ,output logic [31:0]       perf_hits
  ,output logic [31:0]       perf_misses
  ,output logic [31:0]       perf_wr
`endif
);

   localparam int CW = $clog2(TO_CYC + 1);

   state_t            state;
   logic [CW-1:0]     to_cnt;
   logic [CW-1:0]     to_nxt;
   logic [2:0]        lat_width;
   logic [1:0]        lat_off;
   logic [DATA_W-1:0] rd_word;

   logic accept;
   logic ld_hit;
   logic ld_miss;
   logic st;
   logic to_hit;

   assign accept  = (state == IDLE) && cpu_req;
   assign ld_hit  = accept && !cpu_wen && c_hit;
   assign ld_miss = accept && !cpu_wen && !c_hit;
   assign st      = accept && cpu_wen;

   // Fires in the TO_CYC-th cycle spent waiting in a RAM state.
   assign to_hit = (state inside {RD_REQ, RD_WAIT, WR_REQ})
                && (to_cnt == CW'(TO_CYC - 1));
   assign to_nxt = (to_cnt == CW'(TO_CYC)) ? to_cnt : to_cnt + CW'(1);

   always_comb begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      cpu_err   = 1'b0;
      c_fill    = 1'b0;
      c_wr      = 1'b0;
      c_be      = '0;
      c_wdata   = '0;
      unique case (state)
         IDLE: begin
            cpu_stall = ld_miss || st;
            if (ld_hit)
               cpu_rdata = load_extract(c_rdata, cpu_width,
                                        cpu_addr[1:0]);
            if (st && c_hit) begin
               c_wr    = 1'b1;
               c_be    = be_from_width(cpu_width, cpu_addr[1:0]);
               c_wdata = store_data(cpu_width, cpu_wdata);
            end
         end
         RD_REQ, RD_WAIT: begin
            cpu_stall = !to_hit
                     || (state == RD_REQ ? ram_ack : ram_rvalid);
            cpu_err   = !cpu_stall;
         end
         FILL: begin
            c_fill    = 1'b1;
            c_wdata   = rd_word;
            cpu_rdata = load_extract(rd_word, lat_width, lat_off);
         end
         WR_REQ: begin
            cpu_stall = !(ram_ack || to_hit);
            cpu_err   = to_hit && !ram_ack;
         end
         default: cpu_stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         to_cnt    <= '0;
         ram_req   <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_be    <= '0;
         lat_width <= '0;
         lat_off   <= '0;
         rd_word   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               to_cnt <= '0;
               if (ld_miss) begin
                  state     <= RD_REQ;
                  ram_req   <= 1'b1;
                  ram_we    <= 1'b0;
                  ram_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                  ram_wdata <= '0;
                  ram_be    <= '0;
                  lat_width <= cpu_width;
                  lat_off   <= cpu_addr[1:0];
               end else if (st) begin
                  state     <= WR_REQ;
                  ram_req   <= 1'b1;
                  ram_we    <= 1'b1;
                  ram_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                  ram_wdata <= store_data(cpu_width, cpu_wdata);
                  ram_be    <= be_from_width(cpu_width,
                                             cpu_addr[1:0]);
               end
            end
            RD_REQ: begin
               if (ram_ack) begin
                  state   <= RD_WAIT;
                  ram_req <= 1'b0;
                  to_cnt  <= '0;
               end else if (to_hit) begin
                  state   <= IDLE;
                  ram_req <= 1'b0;
                  to_cnt  <= '0;
               end else begin
                  to_cnt  <= to_nxt;
               end
            end
            RD_WAIT: begin
               if (ram_rvalid) begin
                  state   <= FILL;
                  rd_word <= ram_rdata;
                  to_cnt  <= '0;
               end else if (to_hit) begin
                  state   <= IDLE;
                  to_cnt  <= '0;
               end else begin
                  to_cnt  <= to_nxt;
               end
            end
            FILL: begin
               state  <= IDLE;
               to_cnt <= '0;
            end
            WR_REQ: begin
               if (ram_ack || to_hit) begin
                  state   <= IDLE;
                  ram_req <= 1'b0;
                  ram_we  <= 1'b0;
                  to_cnt  <= '0;
               end else begin
                  to_cnt  <= to_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_PERF_EN
   dcache_perf_cnt u_perf (
      .clk         (clk),
      .rst_n       (rst_n),
      .hit_inc     (ld_hit),
      .miss_inc    (ld_miss),
      .wr_inc      (st),
      .perf_hits   (perf_hits),
      .perf_misses (perf_misses),
      .perf_wr     (perf_wr)
   );
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: hit/miss loads, stores, timeout,
// mid-transaction reset; perf counters checked when DCACHE_PERF_EN is set.
module tb_dcache_miss_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_wen = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [2:0]  cpu_width = '0;
   logic        cpu_stall;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic        c_hit = 1'b0;
   logic [31:0] c_rdata = '0;
   logic        c_fill;
   logic        c_wr;
   logic [3:0]  c_be;
   logic [31:0] c_wdata;
   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_be;
   logic        ram_ack = 1'b0;
   logic        ram_rvalid = 1'b0;
   logic [31:0] ram_rdata = '0;
`ifdef DCACHE_PERF_EN
   logic [31:0] perf_hits;
   logic [31:0] perf_misses;
   logic [31:0] perf_wr;
`endif

   int n_chk = 0;
   int n_err = 0;
   int e_hits = 0;
   int e_miss = 0;
   int e_wr = 0;

   logic [31:0] rd_q[$];
   logic [31:0] fill_q[$];

   int          r_cycles, r_fills, r_errs, r_err_k, r_reqs;
   logic        r_we, r_cwr;
   logic [3:0]  r_be, r_cbe;
   logic [31:0] r_wdata, r_addr, r_cwdata;

   always #5 clk = ~clk;

   dcache_miss_ctrl #(.ADDR_W(32), .DATA_W(32), .TO_CYC(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_wen    (cpu_wen),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_width  (cpu_width),
      .cpu_stall  (cpu_stall),
      .cpu_rdata  (cpu_rdata),
      .cpu_err    (cpu_err),
      .c_hit      (c_hit),
      .c_rdata    (c_rdata),
      .c_fill     (c_fill),
      .c_wr       (c_wr),
      .c_be       (c_be),
      .c_wdata    (c_wdata),
      .ram_req    (ram_req),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_be     (ram_be),
      .ram_ack    (ram_ack),
      .ram_rvalid (ram_rvalid),
      .ram_rdata  (ram_rdata)
`ifdef DCACHE_PERF_EN
     ,.perf_hits  (perf_hits)
     ,.perf_misses(perf_misses)
     ,.perf_wr    (perf_wr)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Completed loads and refills are compared against queued expectations.
   always @(negedge clk) begin
      if (rst_n && cpu_req && !cpu_wen && !cpu_stall) begin
         if (rd_q.size() == 0) chk("rd_unexpected", cpu_rdata, 32'hx);
         else chk("cpu_rdata", cpu_rdata, rd_q.pop_front());
      end
      if (rst_n && c_fill) begin
         if (fill_q.size() == 0) chk("fill_unexpected", c_wdata, 32'hx);
         else chk("c_fill_data", c_wdata, fill_q.pop_front());
      end
   end

   task automatic drive(input logic wen, input logic [31:0] addr,
                        input logic [2:0] width, input logic [31:0] wd,
                        input logic hit, input logic [31:0] crd);
      @(posedge clk);
      #1;
      cpu_req   = 1'b1;
      cpu_wen   = wen;
      cpu_addr  = addr;
      cpu_width = width;
      cpu_wdata = wd;
      c_hit     = hit;
      c_rdata   = crd;
      ram_ack   = 1'b0;
      ram_rvalid = 1'b0;
      if (wen) e_wr++;
      else if (hit) e_hits++;
      else e_miss++;
   endtask

   task automatic idle_cyc();
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      cpu_wen = 1'b0;
      c_hit   = 1'b0;
   endtask

   // Plays the RAM side until the stall drops; ack_wait<0 never acks.
   task automatic run_access(input int ack_wait, input int rv_wait,
                             input logic [31:0] rd);
      int rq;
      int since;
      bit done;
      rq = 0; since = -1; done = 0;
      r_cycles = 0; r_fills = 0; r_errs = 0; r_err_k = -1; r_reqs = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         ram_ack = 1'b0;
         ram_rvalid = 1'b0;
         if (ram_req) begin
            rq++;
            r_reqs++;
            r_we = ram_we; r_be = ram_be;
            r_wdata = ram_wdata; r_addr = ram_addr;
            if (ack_wait >= 0 && rq == ack_wait + 1) begin
               ram_ack = 1'b1;
               if (!ram_we) since = 0;
            end
         end else if (since >= 0) begin
            since++;
            if (since == rv_wait) begin
               ram_rvalid = 1'b1;
               ram_rdata  = rd;
               since = -1;
            end
         end
         @(negedge clk);
         r_cycles++;
         if (k == 0) begin
            r_cwr = c_wr; r_cbe = c_be; r_cwdata = c_wdata;
         end
         if (c_fill) r_fills++;
         if (cpu_err) begin
            r_errs++;
            r_err_k = k;
         end
         if (!cpu_stall) done = 1;
      end
      if (!done) chk("access_bound", 32'd0, 32'd1);
   endtask

   initial begin
      #3;
      chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
      chk("rst_ram_req", {31'b0, ram_req}, 32'd0);
      chk("rst_outs", {28'b0, c_fill, c_wr, cpu_err, ram_we}, 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      #20;
      rst_n = 1'b1;

      // LB hit at 0x10: byte 0xF0 sign-extended, no stall, no RAM.
      drive(1'b0, 32'h10, 3'b010, 32'h0, 1'b1, 32'h8000_00F0);
      rd_q.push_back(32'hFFFF_FFF0);
      run_access(0, 1, 32'h0);
      chk("hit_cycles", r_cycles, 32'd1);
      chk("hit_no_ram", r_reqs, 32'd0);

      // LHU miss at 0x22, ack on 3rd req cycle, rvalid one later.
      drive(1'b0, 32'h22, 3'b101, 32'h0, 1'b0, 32'h0);
      rd_q.push_back(32'h0000_BEEF);
      fill_q.push_back(32'hBEEF_1234);
      run_access(2, 1, 32'hBEEF_1234);
      chk("miss1_cycles", r_cycles, 32'd6);
      chk("miss1_fills", r_fills, 32'd1);
      chk("miss1_addr", r_addr, 32'h20);
      chk("miss1_we", {31'b0, r_we}, 32'd0);

      // LW miss at misaligned 0x27, fastest RAM: 4-cycle sequence.
      drive(1'b0, 32'h27, 3'b000, 32'h0, 1'b0, 32'h0);
      rd_q.push_back(32'h1122_3344);
      fill_q.push_back(32'h1122_3344);
      run_access(0, 1, 32'h1122_3344);
      chk("miss2_cycles", r_cycles, 32'd4);
      chk("miss2_addr", r_addr, 32'h24);

      // Back-to-back LH hit on upper half.
      drive(1'b0, 32'h02, 3'b001, 32'h0, 1'b1, 32'h8001_7FFF);
      rd_q.push_back(32'hFFFF_8001);
      run_access(0, 1, 32'h0);
      chk("lh_cycles", r_cycles, 32'd1);

      // SB 0xA5 at 0x13, hit.
      drive(1'b1, 32'h13, 3'b010, 32'h0000_00A5, 1'b1, 32'h0);
      run_access(0, 1, 32'h0);
      chk("sb_c_wr", {31'b0, r_cwr}, 32'd1);
      chk("sb_c_be", {28'b0, r_cbe}, 32'h8);
      chk("sb_c_wdata", r_cwdata, 32'hA5A5_A5A5);
      chk("sb_ram_we", {31'b0, r_we}, 32'd1);
      chk("sb_ram_be", {28'b0, r_be}, 32'h8);
      chk("sb_ram_wdata", r_wdata, 32'hA5A5_A5A5);
      chk("sb_ram_addr", r_addr, 32'h10);
      chk("sb_cycles", r_cycles, 32'd2);

      // SH miss at 0x06: no cache write, no allocate.
      drive(1'b1, 32'h06, 3'b001, 32'h0000_5678, 1'b0, 32'h0);
      run_access(1, 1, 32'h0);
      chk("sh_c_wr", {31'b0, r_cwr}, 32'd0);
      chk("sh_fills", r_fills, 32'd0);
      chk("sh_ram_be", {28'b0, r_be}, 32'hC);
      chk("sh_ram_wdata", r_wdata, 32'h5678_5678);
      chk("sh_cycles", r_cycles, 32'd3);

      // LBU hit at 0x11.
      drive(1'b0, 32'h11, 3'b110, 32'h0, 1'b1, 32'h0000_9C00);
      rd_q.push_back(32'h0000_009C);

      run_access(0, 1, 32'h0);

      // LW miss with a silent RAM: timeout path returns 0.
      drive(1'b0, 32'h40, 3'b000, 32'h0, 1'b0, 32'h0);
      rd_q.push_back(32'h0);
      run_access(-1, 1, 32'h0);
      chk("to_err_cycle", r_err_k, 32'd64);
      chk("to_err_count", r_errs, 32'd1);
      chk("to_no_fill", r_fills, 32'd0);
      idle_cyc();
      chk("to_ram_req", {31'b0, ram_req}, 32'd0);

      // Hit after timeout proves the FSM is back in IDLE.
      drive(1'b0, 32'h03, 3'b010, 32'h0, 1'b1, 32'h7F00_0000);
      rd_q.push_back(32'h0000_007F);
      run_access(0, 1, 32'h0);
      chk("post_to_cycles", r_cycles, 32'd1);

      idle_cyc();
      chk("idle_stall", {31'b0, cpu_stall}, 32'd0);

`ifdef DCACHE_PERF_EN
      @(negedge clk);
      chk("perf_hits", perf_hits, 32'(e_hits));
      chk("perf_misses", perf_misses, 32'(e_miss));
      chk("perf_wr", perf_wr, 32'(e_wr));
`endif

      // Reset while waiting for read data.
      drive(1'b0, 32'h50, 3'b000, 32'h0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      ram_ack = 1'b1;
      @(posedge clk);
      #1;
      ram_ack = 1'b0;
      chk("rw_stall", {31'b0, cpu_stall}, 32'd1);
      #2;
      rst_n = 1'b0;
      cpu_req = 1'b0;
      e_hits = 0; e_miss = 0; e_wr = 0;
      #1;
      chk("arst_stall", {31'b0, cpu_stall}, 32'd0);
      chk("arst_ram_req", {31'b0, ram_req}, 32'd0);
      chk("arst_fill", {31'b0, c_fill}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 32'hCAFE_F00D);
      rd_q.push_back(32'hCAFE_F00D);
      run_access(0, 1, 32'h0);
      chk("post_rst_cycles", r_cycles, 32'd1);
      idle_cyc();

`ifdef DCACHE_PERF_EN
      @(negedge clk);
      chk("perf_hits_rst", perf_hits, 32'(e_hits));
      chk("perf_miss_rst", perf_misses, 32'(e_miss));
`endif

      chk("rd_q_empty", rd_q.size(), 32'd0);
      chk("fill_q_empty", fill_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
